atm_session_ctrl: RTL and testbench

Session-level controller that sits directly upstream of the ATM transaction core. It converts card insertion, ENTER/BACK buttons and menu selection into the 16-bit one-hot current_state and single-cycle ready strobes that the core consumes. It samples the core's status_code after each strobe and routes the flow: next step, retry, ERROR or SUCCESS. It also enforces PIN-retry lockout and an inactivity logout.

---
 rtl/atm_pkg.sv | 49 ++++
 rtl/atm_btn_edge.sv | 26 ++
 rtl/atm_session_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller: one-hot session
// states, currency codes, menu option codes and the core's OK status.
package atm_pkg;

    // One-hot session state presented to the ATM core, IDLE = bit0 .. SUCCESS = bit14.
    typedef enum logic [15:0] {
        ST_IDLE                      = 16'h0001,
        ST_ACC_NUM                   = 16'h0002,
        ST_PIN_INPUT                 = 16'h0004,
        ST_MENU                      = 16'h0008,
        ST_SHOW_BALANCES             = 16'h0010,
        ST_CONVERT_CURRENCY          = 16'h0020,
        ST_SELECT_CURRENCY_CONVERT_1 = 16'h0040,
        ST_SELECT_CURRENCY_CONVERT_2 = 16'h0080,
        ST_WITHDRAW                  = 16'h0100,
        ST_SELECT_AMOUNT_WITHDRAW    = 16'h0200,
        ST_TRANSFER                  = 16'h0400,
        ST_SELECT_CURRENCY_TRANSFER  = 16'h0800,
        ST_SELECT_AMOUNT_TRANSFER    = 16'h1000,
        ST_ERROR                     = 16'h2000,
        ST_SUCCESS                   = 16'h4000
    } atm_state_e;

    typedef enum logic [2:0] {
        CUR_USD = 3'd0,
        CUR_BTC = 3'd1,
        CUR_ETH = 3'd2,
        CUR_XRP = 3'd3,
        CUR_LTC = 3'd4
    } currency_e;

    typedef enum logic [1:0] {
        OPT_BALANCES = 2'b00,
        OPT_CONVERT  = 2'b01,
        OPT_WITHDRAW = 2'b10,
        OPT_TRANSFER = 2'b11
    } menu_opt_e;

    localparam logic [3:0] STATUS_OK = 4'd0;

    // States in which ENTER hands a request to the core (ready strobe + status wait).
    function automatic logic is_txn_state(atm_state_e s);
        return (s == ST_ACC_NUM)                   || (s == ST_PIN_INPUT) ||
               (s == ST_SELECT_CURRENCY_CONVERT_1) || (s == ST_SELECT_CURRENCY_CONVERT_2) ||
               (s == ST_SELECT_AMOUNT_WITHDRAW)    || (s == ST_TRANSFER) ||
               (s == ST_SELECT_AMOUNT_TRANSFER);
    endfunction

endpackage

// File: rtl/atm_btn_edge.sv
// Two-flop rising-edge detector for a debounced button level.
// ev_o is high for exactly one cycle per press.
module atm_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic ev_o
);

    logic lvl_q;
    logic lvl_prev_q;

    // Register the level and its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            lvl_q      <= btn_i;
            lvl_prev_q <= lvl_q;
        end
    end

    assign ev_o = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: turns card/button/menu inputs into the one-hot
// current_state and ready strobes for the ATM core, and routes the flow on
// the core's status_code.
// Handshake: a transaction ENTER raises ready for exactly one cycle and busy
// from that cycle on; status_code is sampled RESP_LAT cycles after the ready
// cycle, on the same edge that clears busy and moves current_state.
// Optional feature macro: ATM_TIMEOUT_EN (inactivity logout).
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned RESP_LAT       = 2,
    parameter int unsigned MAX_PIN_TRIES  = 3,
    parameter int unsigned MSG_CYCLES     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        card_in,
    input  logic        enter_btn,
    input  logic        back_btn,
    input  logic [1:0]  menuOption,
    input  logic [3:0]  status_code,
    output logic [15:0] current_state,
    output logic        ready,
    output logic        authenticated,
    output logic        pin_locked,
    output logic        busy
);

    localparam int LAT_W = (RESP_LAT > 0) ? $clog2(RESP_LAT + 1) : 1;
    localparam int MSG_W = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES + 1) : 1;

    atm_state_e     state_q, state_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic           auth_q, auth_d;
    logic           lock_q, lock_d;
    logic [2:0]     retry_q, retry_d;
    logic [MSG_W-1:0] msg_cnt_q, msg_cnt_d;
    logic           card_prev_q;

    logic           enter_ev;
    logic           back_ev;
    logic           card_rise;
    logic           msg_done;
    logic           status_ok;
    logic           timeout_hit;

    atm_btn_edge u_enter_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (enter_btn),
        .ev_o  (enter_ev)
    );

    atm_btn_edge u_back_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (back_btn),
        .ev_o  (back_ev)
    );

    assign card_rise = card_in & ~card_prev_q;
    assign msg_done  = (msg_cnt_q == MSG_W'(MSG_CYCLES - 1));
    assign status_ok = (status_code == STATUS_OK);

`ifdef ATM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            activity;

    // Inactivity counter: idle outside IDLE, cleared by any activity, held at zero while busy.
    always_comb begin
        activity    = enter_ev | back_ev | (card_in ^ card_prev_q);
        timeout_hit = (state_q != ST_IDLE) && !busy_q && !activity &&
                      (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        if ((state_q == ST_IDLE) || busy_q || activity || timeout_hit) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Inactivity counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and output logic; card removal has top priority, then the busy window.
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        lat_cnt_d = lat_cnt_q;
        auth_d    = auth_q;
        lock_d    = lock_q;
        retry_d   = retry_q;
        msg_cnt_d = '0;

        if (!card_in) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            lat_cnt_d = '0;
            lock_d    = 1'b0;
            retry_d   = '0;
        end else if (busy_q) begin
            if (lat_cnt_q == LAT_W'(RESP_LAT)) begin
                busy_d    = 1'b0;
                lat_cnt_d = '0;
                if (status_ok) begin
                    case (state_q)
                        ST_ACC_NUM:                   state_d = ST_PIN_INPUT;
                        ST_PIN_INPUT: begin
                            state_d = ST_MENU;
                            auth_d  = 1'b1;
                            retry_d = '0;
                        end
                        ST_SELECT_CURRENCY_CONVERT_1: state_d = ST_SELECT_CURRENCY_CONVERT_2;
                        ST_SELECT_CURRENCY_CONVERT_2: state_d = ST_SUCCESS;
                        ST_SELECT_AMOUNT_WITHDRAW:    state_d = ST_SUCCESS;
                        ST_TRANSFER:                  state_d = ST_SELECT_CURRENCY_TRANSFER;
                        ST_SELECT_AMOUNT_TRANSFER:    state_d = ST_SUCCESS;
                        default:                      state_d = state_q;
                    endcase
                end else if (state_q == ST_PIN_INPUT) begin
                    retry_d = retry_q + 3'd1;
                    if (retry_d == 3'(MAX_PIN_TRIES)) begin
                        lock_d  = 1'b1;
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_ERROR;
                end
            end else begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
        end else if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (is_txn_state(state_q)) begin
            // Back beats enter when both fire in the same cycle.
            if (back_ev) begin
                state_d = ((state_q == ST_ACC_NUM) || (state_q == ST_PIN_INPUT)) ? ST_IDLE : ST_MENU;
            end else if (enter_ev) begin
                ready_d   = 1'b1;
                busy_d    = 1'b1;
                lat_cnt_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (card_rise && !lock_q) state_d = ST_ACC_NUM;
                end
                ST_MENU: begin
                    if (back_ev) begin
                        state_d = ST_IDLE;
                    end else if (enter_ev) begin
                        case (menuOption)
                            OPT_BALANCES: state_d = ST_SHOW_BALANCES;
                            OPT_CONVERT:  state_d = ST_CONVERT_CURRENCY;
                            OPT_WITHDRAW: state_d = ST_WITHDRAW;
                            default:      state_d = ST_TRANSFER;
                        endcase
                    end
                end
                ST_SHOW_BALANCES: begin
                    if (back_ev || enter_ev) state_d = ST_MENU;
                end
                ST_CONVERT_CURRENCY: begin
                    if (back_ev)       state_d = ST_MENU;
                    else if (enter_ev) state_d = ST_SELECT_CURRENCY_CONVERT_1;
                end
                ST_WITHDRAW: begin
                    if (back_ev)       state_d = ST_MENU;
                    else if (enter_ev) state_d = ST_SELECT_AMOUNT_WITHDRAW;
                end
                ST_SELECT_CURRENCY_TRANSFER: begin
                    if (back_ev)       state_d = ST_MENU;
                    else if (enter_ev) state_d = ST_SELECT_AMOUNT_TRANSFER;
                end
                ST_ERROR: begin
                    if (msg_done) state_d = (lock_q || !auth_q) ? ST_IDLE : ST_MENU;
                    else          msg_cnt_d = msg_cnt_q + MSG_W'(1);
                end
                ST_SUCCESS: begin
                    if (msg_done) state_d = ST_MENU;
                    else          msg_cnt_d = msg_cnt_q + MSG_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Every route back to IDLE ends the authenticated session.
        if (state_d == ST_IDLE) auth_d = 1'b0;
    end

    // State and session registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            lat_cnt_q   <= '0;
            auth_q      <= 1'b0;
            lock_q      <= 1'b0;
            retry_q     <= '0;
            msg_cnt_q   <= '0;
            card_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            lat_cnt_q   <= lat_cnt_d;
            auth_q      <= auth_d;
            lock_q      <= lock_d;
            retry_q     <= retry_d;
            msg_cnt_q   <= msg_cnt_d;
            card_prev_q <= card_in;
        end
    end

    assign current_state = state_q;
    assign ready         = ready_q;
    assign authenticated = auth_q;
    assign pin_locked    = lock_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl: directed vector table, hand-written
// busy/reset/timeout sequences, then randomized sessions against an
// action-level reference model.
module tb_atm_session_ctrl;

    localparam int TB_LAT  = 2;
    localparam int TB_MAX  = 3;
    localparam int TB_MSG  = 100;
    localparam int TB_TO   = 300;

    localparam int K_CARD  = 0;
    localparam int K_PRESS = 1;
    localparam int K_MSG   = 2;

    logic        clk;
    logic        rst_n;
    logic        card_in;
    logic        enter_btn;
    logic        back_btn;
    logic [1:0]  menuOption;
    logic [3:0]  status_code;
    logic [15:0] current_state;
    logic        ready;
    logic        authenticated;
    logic        pin_locked;
    logic        busy;

    atm_session_ctrl #(
        .RESP_LAT       (TB_LAT),
        .MAX_PIN_TRIES  (TB_MAX),
        .MSG_CYCLES     (TB_MSG),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .card_in       (card_in),
        .enter_btn     (enter_btn),
        .back_btn      (back_btn),
        .menuOption    (menuOption),
        .status_code   (status_code),
        .current_state (current_state),
        .ready         (ready),
        .authenticated (authenticated),
        .pin_locked    (pin_locked),
        .busy          (busy)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Ready pulse counter, sampled on the falling edge.
    int ready_seen = 0;
    always @(negedge clk) if (ready) ready_seen++;

    int n_vec = 0;
    int n_err = 0;
    int rdy_base = 0;

    typedef struct {
        int          kind;
        bit          e;
        bit          b;
        logic [1:0]  opt;
        logic [3:0]  st;
        logic [15:0] exp_state;
        int          exp_rdy;
        bit          exp_auth;
        bit          exp_lock;
    } vec_t;

    vec_t tbl[$];

    // Reference model: session state as a bit index into current_state.
    int m_st;
    bit m_auth;
    bit m_lock;
    int m_retry;
    int ok_next[15];
    int menu_tgt[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] st, input int rdy,
                             input bit auth, input bit lock);
        check({name, ".state"}, 32'(current_state), 32'(st));
        check({name, ".ready_pulses"}, 32'(ready_seen - rdy_base), 32'(rdy));
        check({name, ".auth"}, 32'(authenticated), 32'(auth));
        check({name, ".lock"}, 32'(pin_locked), 32'(lock));
        check({name, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic card_cycle();
        rdy_base = ready_seen;
        card_in = 1'b0;
        tick();
        card_in = 1'b1;
        tick();
    endtask

    // One button action, then enough cycles for any transaction to resolve.
    task automatic do_action(input bit e, input bit b, input logic [1:0] opt, input logic [3:0] st);
        rdy_base    = ready_seen;
        menuOption  = opt;
        status_code = st;
        enter_btn   = e;
        back_btn    = b;
        tick();
        enter_btn   = 1'b0;
        back_btn    = 1'b0;
        tick();
        repeat (TB_LAT + 1) tick();
    endtask

    function automatic bit m_is_txn(int s);
        return (s == 1) || (s == 2) || (s == 6) || (s == 7) || (s == 9) || (s == 10) || (s == 12);
    endfunction

    task automatic model_press(input bit e, input bit b, input logic [1:0] opt,
                               input logic [3:0] st, output int exp_rdy);
        exp_rdy = 0;
        if (b) begin
            if (m_st >= 1 && m_st <= 3) m_st = 0;
            else if (m_st >= 4 && m_st <= 12) m_st = 3;
        end else if (e) begin
            if (m_is_txn(m_st)) begin
                exp_rdy = 1;
                if (st == 4'd0) begin
                    if (m_st == 2) begin
                        m_auth  = 1'b1;
                        m_retry = 0;
                    end
                    m_st = ok_next[m_st];
                end else if (m_st == 2) begin
                    m_retry++;
                    if (m_retry == TB_MAX) begin
                        m_lock = 1'b1;
                        m_st   = 13;
                    end
                end else begin
                    m_st = 13;
                end
            end else begin
                case (m_st)
                    3:       m_st = menu_tgt[opt];
                    4:       m_st = 3;
                    5:       m_st = 6;
                    8:       m_st = 9;
                    11:      m_st = 12;
                    default: m_st = m_st;
                endcase
            end
        end
        if (m_st == 0) m_auth = 1'b0;
    endtask

    task automatic add(input int kind, input bit e, input bit b, input logic [1:0] opt,
                       input logic [3:0] st, input logic [15:0] es, input int er,
                       input bit ea, input bit el);
        vec_t v;
        v.kind = kind; v.e = e; v.b = b; v.opt = opt; v.st = st;
        v.exp_state = es; v.exp_rdy = er; v.exp_auth = ea; v.exp_lock = el;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t        v;
        logic [15:0] held;
        int          r;
        int          exp_rdy;
        bit          e;
        bit          b;
        logic [1:0]  opt;
        logic [3:0]  st;

        ok_next = '{default: 0};
        ok_next[1] = 2; ok_next[2] = 3; ok_next[6] = 7; ok_next[7] = 14;
        ok_next[9] = 14; ok_next[10] = 11; ok_next[12] = 14;
        menu_tgt = '{4, 5, 8, 10};

        // Directed table: login, convert, transfer error, balances, withdraw, lockout.
        add(K_CARD,  0, 0, 2'b00, 4'h0, 16'h0002, 0, 0, 0);
        add(K_PRESS, 1, 0, 2'b00, 4'h0, 16'h0004, 1, 0, 0);
        add(K_PRESS, 1, 0, 2'b00, 4'h0, 16'h0008, 1, 1, 0);
        add(K_PRESS, 1, 0, 2'b01, 4'h0, 16'h0020, 0, 1, 0);
        add(K_PRESS, 1, 0, 2'b01, 4'h0, 16'h0040, 0, 1, 0);
        add(K_PRESS, 1, 0, 2'b01, 4'h0, 16'h0080, 1, 1, 0);
        add(K_PRESS, 1, 0, 2'b01, 4'h0, 16'h4000, 1, 1, 0);
        add(K_MSG,   0, 0, 2'b00, 4'h0, 16'h0008, 0, 1, 0);
        add(K_PRESS, 1, 0, 2'b11, 4'h0, 16'h0400, 0, 1, 0);
        add(K_PRESS, 1, 0, 2'b11, 4'h0, 16'h0800, 1, 1, 0);
        add(K_PRESS, 1, 0, 2'b11, 4'h0, 16'h1000, 0, 1, 0);
        add(K_PRESS, 1, 0, 2'b11, 4'h2, 16'h2000, 1, 1, 0);
        add(K_MSG,   0, 0, 2'b00, 4'h0, 16'h0008, 0, 1, 0);
        add(K_PRESS, 1, 0, 2'b00, 4'h0, 16'h0010, 0, 1, 0);
        add(K_PRESS, 1, 1, 2'b00, 4'h0, 16'h0008, 0, 1, 0);
        add(K_PRESS, 1, 0, 2'b10, 4'h0, 16'h0100, 0, 1, 0);
        add(K_PRESS, 1, 0, 2'b10, 4'h0, 16'h0200, 0, 1, 0);
        add(K_PRESS, 1, 1, 2'b10, 4'h0, 16'h0008, 0, 1, 0);
        add(K_PRESS, 0, 1, 2'b00, 4'h0, 16'h0001, 0, 0, 0);
        add(K_CARD,  0, 0, 2'b00, 4'h0, 16'h0002, 0, 0, 0);
        add(K_PRESS, 1, 0, 2'b00, 4'h0, 16'h0004, 1, 0, 0);
        add(K_PRESS, 1, 0, 2'b00, 4'h3, 16'h0004, 1, 0, 0);
        add(K_PRESS, 1, 0, 2'b00, 4'h3, 16'h0004, 1, 0, 0);
        add(K_PRESS, 1, 0, 2'b00, 4'h3, 16'h2000, 1, 0, 1);
        add(K_MSG,   0, 0, 2'b00, 4'h0, 16'h0001, 0, 0, 1);
        add(K_PRESS, 1, 0, 2'b00, 4'h0, 16'h0001, 0, 0, 1);
        add(K_CARD,  0, 0, 2'b00, 4'h0, 16'h0002, 0, 0, 0);

        // Reset.
        rst_n = 1'b0; card_in = 1'b0; enter_btn = 1'b0; back_btn = 1'b0;
        menuOption = 2'b00; status_code = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rdy_base = ready_seen;
        check("reset.ready_now", 32'(ready), 32'd0);
        check_all("reset", 16'h0001, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Directed vectors.
        held = 16'h0001;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            case (v.kind)
                K_CARD:  card_cycle();
                K_PRESS: do_action(v.e, v.b, v.opt, v.st);
                default: begin
                    rdy_base = ready_seen;
                    repeat (TB_MSG - 1) tick();
                    check($sformatf("vec%0d.msg_hold", i), 32'(current_state), 32'(held));
                    tick();
                end
            endcase
            check_all($sformatf("vec%0d", i), v.exp_state, v.exp_rdy, v.exp_auth, v.exp_lock);
            held = v.exp_state;
        end

        // Back during busy is ignored: ACC_NUM resolves to PIN_INPUT.
        rdy_base = ready_seen; status_code = 4'h0;
        enter_btn = 1'b1; tick(); enter_btn = 1'b0; tick();
        check("busy_seq.busy_set", 32'(busy), 32'd1);
        check("busy_seq.ready_now", 32'(ready), 32'd1);
        back_btn = 1'b1; tick(); back_btn = 1'b0; tick();
        check("busy_seq.busy_hold", 32'(busy), 32'd1);
        tick();
        check_all("busy_back", 16'h0004, 1, 0, 0);

        // Enter during busy gives no second ready: PIN_INPUT resolves to MENU.
        rdy_base = ready_seen;
        enter_btn = 1'b1; tick(); enter_btn = 1'b0; tick();
        enter_btn = 1'b1; tick(); enter_btn = 1'b0; tick();
        tick();
        check_all("busy_enter", 16'h0008, 1, 1, 0);

`ifdef ATM_TIMEOUT_EN
        // Inactivity in MENU forces logout exactly at the timeout boundary.
        repeat (TB_TO - 1) tick();
        check("timeout.before", 32'(current_state), 32'h0008);
        tick();
        check("timeout.state", 32'(current_state), 32'h0001);
        check("timeout.auth", 32'(authenticated), 32'd0);
        card_cycle();
        do_action(1, 0, 2'b00, 4'h0);
        do_action(1, 0, 2'b00, 4'h0);
        check("timeout.relogin", 32'(current_state), 32'h0008);
`endif

        // Asynchronous reset in the middle of a busy window.
        do_action(1, 0, 2'b10, 4'h0);
        do_action(1, 0, 2'b10, 4'h0);
        check("rst_seq.at_saw", 32'(current_state), 32'h0200);
        enter_btn = 1'b1; tick(); enter_btn = 1'b0; tick();
        check("rst_seq.ready_before", 32'(ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_seq.state", 32'(current_state), 32'h0001);
        check("rst_seq.ready", 32'(ready), 32'd0);
        check("rst_seq.busy", 32'(busy), 32'd0);
        check("rst_seq.auth", 32'(authenticated), 32'd0);
        card_in = 1'b0;
        tick(); tick();
        #3 rst_n = 1'b1;
        rdy_base = ready_seen;
        repeat (6) tick();
        check_all("rst_after", 16'h0001, 0, 0, 0);

        // Randomized sessions against the reference model.
        m_st = 0; m_auth = 1'b0; m_lock = 1'b0; m_retry = 0;
        for (int i = 0; i < 120; i++) begin
            if (m_st == 0) begin
                card_cycle();
                m_st = 1; m_auth = 1'b0; m_lock = 1'b0; m_retry = 0;
                check_all($sformatf("rnd%0d.card", i), 16'(1 << m_st), 0, m_auth, m_lock);
            end else begin
                r   = $urandom_range(0, 11);
                e   = (r <= 9) || (r == 11);
                b   = (r >= 10);
                opt = 2'($urandom_range(0, 3));
                st  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                model_press(e, b, opt, st, exp_rdy);
                do_action(e, b, opt, st);
                check_all($sformatf("rnd%0d", i), 16'(1 << m_st), exp_rdy, m_auth, m_lock);
                if (m_st == 13 || m_st == 14) begin
                    rdy_base = ready_seen;
                    repeat (TB_MSG - 1) tick();
                    check($sformatf("rnd%0d.msg_hold", i), 32'(current_state), 32'(1 << m_st));
                    tick();
                    if (m_st == 13) m_st = (m_lock || !m_auth) ? 0 : 3;
                    else            m_st = 3;
                    if (m_st == 0) m_auth = 1'b0;
                    check_all($sformatf("rnd%0d.msg_exit", i), 16'(1 << m_st), 0, m_auth, m_lock);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
